rf_mp: RTL
==========

Name: rf_mp

Overview:
- Parametrised multi-port integer register file; successor to the fixed 4-read/2-write RF in the decode/issue stage.
- Generalises port counts and widths.
- Adds a per-register busy scoreboard for the dual-issue hazard check.
- Adds a sequential clear sequencer after reset, so storage can later be mapped to LUTRAM.
- Writes move to the rising edge; same-cycle forwarding is optional.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- NRD, 4, number of read ports
- NWR, 2, number of write ports; a higher index has higher priority

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high once the clear sequence has completed
- raddr  in  NRD*ADDR_W  packed read addresses; port j occupies bits [j*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  packed read data, combinational
- rbusy  out  NRD  busy bit of each read address, combinational
- we  in  NWR  write enables
- waddr  in  NWR*ADDR_W  packed write addresses
- wdata  in  NWR*DATA_W  packed write data
- alloc_v  in  1  mark a destination register busy (issue of a producer)
- alloc_addr  in  ADDR_W  destination register to mark busy

Behaviour:
- Reset and clear FSM, states CLEAR and RUN:
  - Any cycle with rst=1: state<=CLEAR, clr_ptr<=1, all busy<=0, ready<=0.
  - In CLEAR with rst=0, each cycle: rf[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1, that register is cleared and state<=RUN, ready<=1 on the same edge.
  - Result: ready rises DEPTH-1 edges after rst deasserts; 31 edges at default.
  - rst asserted mid-CLEAR restarts the sequence.
  - RUN is left only through rst.
- While in CLEAR:
  - we and alloc_v are ignored.
  - All rdata=0 and all rbusy=0.
- Register 0:
  - Not stored; always reads 0 and is never busy.
  - Writes and allocs to address 0 are dropped.
- Writes (RUN only):
  - rf[waddr_i]<=wdata_i at the rising edge when we_i=1 and waddr_i!=0.
  - Several ports to the same address in one cycle: the highest index i wins, deterministically.
- Reads:
  - rdata_j = rf[raddr_j], zero latency.
  - Without bypass, a same-cycle write becomes visible on the next cycle.
- Scoreboard (RUN only):
  - alloc_v=1 and alloc_addr!=0 sets busy[alloc_addr].
  - Any write to address a clears busy[a].
  - Alloc and write to the same address in the same cycle: busy ends at 1 (alloc wins; the new producer is outstanding). The data is still written.
  - rbusy_j = busy[raddr_j] as registered state, except as modified by the bypass feature.
- Widths:
  - Addresses are unsigned; no wrap beyond DEPTH.
  - Packed vectors are little-endian by port index.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-to-read forwarding in RUN. If any we_i=1 and waddr_i==raddr_j!=0:
  - rdata_j = wdata of the highest such i, in the same cycle;
  - rbusy_j = 0 that cycle, unless alloc_v with alloc_addr==raddr_j is also present, in which case rbusy_j = 1.
- Undefined:
  - reads show pre-edge storage;
  - rbusy shows the registered busy bit only.

Decomposition:
- def.vh holds:
  - the default widths (DATA_W=32, ADDR_W=5);
  - the state encodings RF_ST_CLEAR=1'b0 and RF_ST_RUN=1'b1;
  - the DATA_BUS and REG_ADDR_BUS macros, reused for the defaults.
- One sub-module, rf_read_port, instantiated NRD times in a generate loop. Per port it contains:
  - the storage read mux;
  - the zero-register check;
  - the CLEAR gating;
  - the bypass compare/priority under RF_BYPASS_EN.
- Write priority and the scoreboard stay in rf_mp.

Test Plan:
- Clear timing: rst high for 2 cycles, then low. ready stays 0 for 30 edges and rises at edge 31. Preload via writes before reset; every raddr reads 0 after ready. we asserted during CLEAR has no effect.
- Write conflict: we=2'b11, waddr0=waddr1=5, wdata0=32'h1111_1111, wdata1=32'h2222_2222. Next cycle rdata for address 5 = 32'h2222_2222.
- Register 0: write 32'hDEAD_BEEF to address 0 and alloc address 0. rdata=0 and rbusy=0 on all ports.
- Scoreboard:
  - alloc 7 gives rbusy=1 next cycle;
  - a write to 7 gives rbusy=0 next cycle;
  - alloc 7 and a write to 7 in the same cycle leave rbusy=1 with the data updated.
- Bypass, RF_BYPASS_EN defined: we0=1, waddr0=9, wdata0=32'hCAFE_0001, raddr2=9. rdata2=32'hCAFE_0001 and rbusy2=0 in the same cycle. Without the macro, rdata2 shows the old value until the next cycle.
- Reset mid-clear: pulse rst at clear cycle 10. ready rises 31 edges after the second deassertion, not earlier.

Source files
------------

// File: rtl/rf_mp_pkg.sv
// Shared definitions for the rf_mp multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   rf_state_e             : clear-sequencer state encoding
package rf_mp_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;

   typedef enum logic {
      RF_ST_CLEAR = 1'b0,
      RF_ST_RUN   = 1'b1
   } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One read port of rf_mp: storage mux, register-0 check, CLEAR gating and,
// with RF_BYPASS_EN defined, same-cycle write-to-read forwarding.
// Ports:
//   run          : high when the file is in RUN (low gates outputs to zero)
//   raddr        : read address
//   rf_data      : full storage image, entry 0 hard-wired to zero
//   busy_all     : registered busy bits, entry 0 hard-wired to zero
//   we/waddr/wdata, alloc_v/alloc_addr : write and alloc traffic (bypass only)
//   rdata, rbusy : combinational read data and busy bit
module rf_read_port
   import rf_mp_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NWR    = 2,
   localparam int unsigned DEPTH = 2**ADDR_W
) (
   input  logic                               run,
   input  logic [ADDR_W-1:0]                  raddr,
   input  logic [DEPTH-1:0][DATA_W-1:0]       rf_data,
   input  logic [DEPTH-1:0]                   busy_all,
`ifdef RF_BYPASS_EN
   input  logic [NWR-1:0]                     we,
   input  logic [NWR*ADDR_W-1:0]              waddr,
   input  logic [NWR*DATA_W-1:0]              wdata,
   input  logic                               alloc_v,
   input  logic [ADDR_W-1:0]                  alloc_addr,
`endif
   output logic [DATA_W-1:0]                  rdata,
   output logic                               rbusy
);

`ifdef RF_BYPASS_EN
   logic hit;
`endif

   always_comb begin
      rdata = rf_data[raddr];
      rbusy = busy_all[raddr];
`ifdef RF_BYPASS_EN
      hit = 1'b0;
      // Ascending scan: the highest-index matching write port wins.
      for (int i = 0; i < NWR; i++) begin
         if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
            hit   = 1'b1;
            rdata = wdata[i*DATA_W +: DATA_W];
            rbusy = 1'b0;
         end
      end
      // A producer issued this cycle keeps the register outstanding.
      if (hit && alloc_v && (alloc_addr == raddr)) begin
         rbusy = 1'b1;
      end
`endif
      if (!run || (raddr == '0)) begin
         rdata = '0;
         rbusy = 1'b0;
      end
   end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-port integer register file with busy scoreboard and a
// post-reset sequential clear. Optional macro RF_BYPASS_EN enables same-cycle
// write-to-read forwarding in the read ports.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ready             : high once the clear sequence has completed
//   raddr/rdata/rbusy : NRD packed read ports (combinational data and busy)
//   we/waddr/wdata    : NWR packed write ports, higher index has priority
//   alloc_v/alloc_addr: mark a destination register busy
module rf_mp
   import rf_mp_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NRD    = 4,
   parameter int unsigned NWR    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        rbusy,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic                  alloc_v,
   input  logic [ADDR_W-1:0]     alloc_addr
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   rf_state_e                     state;
   logic [ADDR_W-1:0]             clr_ptr;
   // Register 0 is not stored; index range starts at 1.
   logic [DEPTH-1:1][DATA_W-1:0]  rf_q;
   logic [DEPTH-1:1]              busy_q;
   logic [DEPTH-1:0][DATA_W-1:0]  rf_all;
   logic [DEPTH-1:0]              busy_all;
   logic                          run;

   assign rf_all   = {rf_q, {DATA_W{1'b0}}};
   assign busy_all = {busy_q, 1'b0};
   assign run      = (state == RF_ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RF_ST_CLEAR;
         clr_ptr <= ADDR_W'(1);
         busy_q  <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            RF_ST_CLEAR: begin
               rf_q[clr_ptr] <= '0;
               clr_ptr       <= clr_ptr + ADDR_W'(1);
               if (clr_ptr == LAST_PTR) begin
                  state <= RF_ST_RUN;
                  ready <= 1'b1;
               end
            end
            RF_ST_RUN: begin
               // Later non-blocking assignments override earlier ones, so the
               // ascending loop gives the highest write port priority.
               for (int i = 0; i < NWR; i++) begin
                  if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0)) begin
                     rf_q[waddr[i*ADDR_W +: ADDR_W]]   <= wdata[i*DATA_W +: DATA_W];
                     busy_q[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
                  end
               end
               // Alloc after writes: a new producer outranks the retiring one.
               if (alloc_v && (alloc_addr != '0)) begin
                  busy_q[alloc_addr] <= 1'b1;
               end
            end
            default: begin
               state <= RF_ST_CLEAR;
            end
         endcase
      end
   end

   for (genvar j = 0; j < NRD; j++) begin : g_rd
      rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NWR    (NWR)
      ) u_rd (
         .run        (run),
         .raddr      (raddr[j*ADDR_W +: ADDR_W]),
         .rf_data    (rf_all),
         .busy_all   (busy_all),
`ifdef RF_BYPASS_EN
         .we         (we),
         .waddr      (waddr),
         .wdata      (wdata),
         .alloc_v    (alloc_v),
         .alloc_addr (alloc_addr),
`endif
         .rdata      (rdata[j*DATA_W +: DATA_W]),
         .rbusy      (rbusy[j])
      );
   end

endmodule
